scan_chain_driver: RTL and testbench
====================================

Name: scan_chain_driver

Overview:
- Sequencer that drives a daisy-chained bank of scan-wrapper designs: clock, data, scan_select and latch_enable.
- Sits directly upstream of the scan chain and replaces bit-banging those four lines from the logic analyser.
- Takes a parallel input word, shifts it into the chain, latches it into the designs, captures the design outputs, and shifts them back into a parallel result register.
- Lives inside the user-project wrapper; its outputs feed the chain's clk, data_in, scan_select and latch_enable, and the chain's data_out returns on scan_data_in.

Parameters:
- NUM_IOS, 8: scan bits per design.
- NUM_DESIGNS, 4: designs in the chain.
- CHAIN_LEN, NUM_IOS*NUM_DESIGNS (32): total chain length. Derived; not overridden.
- CLK_DIV, 1: scan_clk half-period in wb_clk_i cycles, range 1..255.

Ports:
- wb_clk_i  input  1: system clock; the only clock.
- wb_rst_i  input  1: asynchronous, active-high reset.
- start  input  1: one-cycle request. Sampled only in IDLE.
- in_data  input  CHAIN_LEN: word to load into the chain. Captured on the accepted start.
- busy  output  1: high from the cycle after an accepted start until done.
- done  output  1: one-cycle pulse on completion.
- out_data  output  CHAIN_LEN: captured design outputs. Held until the next done.
- scan_clk  output  1: chain clock.
- scan_data_out  output  1: to chain data_in.
- scan_select  output  1: 1 = capture design outputs, 0 = shift.
- latch_enable  output  1: latch scan flops into design inputs.
- scan_data_in  input  1: from chain data_out.

Behaviour:
- Clock and reset:
  - Single clock, wb_clk_i; reset is asynchronous and active-high on wb_rst_i.
  - All outputs are registered. Reset value is 0 for busy, done, out_data, scan_clk, scan_data_out, scan_select and latch_enable.
  - Reset mid-operation aborts immediately to IDLE: chain lines drop to 0, out_data clears, and no done is issued.
- Divider:
  - An 8-bit phase counter counts 0..CLK_DIV-1; the sequencer advances when it wraps.
  - The counter is cleared on every state entry.
- States: IDLE -> LOAD -> LATCH -> CAPTURE -> READ -> FINISH -> IDLE.
- IDLE:
  - Chain lines are 0.
  - start=1 captures in_data into a shift register, clears the bit counter, sets busy and enters LOAD.
  - start while busy is ignored.
- LOAD: repeats CHAIN_LEN times, MSB first; after the last bit, enters LATCH.
  - Low phase: scan_data_out = shift_reg MSB, scan_clk=0 for CLK_DIV cycles.
  - High phase: scan_clk=1 for CLK_DIV cycles, then shift left.
  - After LOAD, in_data[CHAIN_LEN-1] sits in the flop farthest from the driver.
- LATCH: latch_enable=1 for CLK_DIV cycles, scan_clk=0, then enter CAPTURE.
- CAPTURE, three sub-phases of CLK_DIV cycles each:
  - scan_select=1, scan_clk=0.
  - scan_select=1, scan_clk=1.
  - scan_select=0, scan_clk=0.
- READ: repeats CHAIN_LEN times with scan_data_out=0.
  - Low phase: scan_clk=0 for CLK_DIV cycles.
  - On the cycle scan_clk is driven high, scan_data_in is sampled before that edge takes effect: rx <= {rx[CHAIN_LEN-2:0], scan_data_in}.
  - High phase: scan_clk=1 for CLK_DIV cycles.
  - Zeros shifted in during READ do not disturb the designs, because latch_enable stays 0.
- FINISH: out_data <= rx, done=1 and busy=0 in the same cycle, then return to IDLE.
- Latency from start to done: 1 + 2·CLK_DIV·CHAIN_LEN + CLK_DIV + 3·CLK_DIV + 2·CLK_DIV·CHAIN_LEN + 1. With defaults this is 134 cycles.
- Invariants:
  - latch_enable and scan_clk are never high together.
  - scan_select changes only while scan_clk=0.
  - Bit counter wraps at CHAIN_LEN-1 with no off-by-one; exactly CHAIN_LEN scan_clk rising edges occur in LOAD and in READ.
- Back-to-back: start asserted in the cycle done is high is ignored; it is accepted from the next cycle.

Test Plan:
- Reset, then idle for 10 cycles: all outputs stay 0, no scan_clk edges.
- Run against a behavioural 4×8 chain model in which each design's outputs = inputs XOR 8'hA5:
  - Defaults, start with in_data=32'h0123_4567: done at cycle 134 after start, out_data=32'hA486_E0C2.
  - Count scan_clk rising edges: 32 in LOAD, 1 in CAPTURE, 32 in READ.
- CLK_DIV=3, in_data=32'hFFFF_0000: every scan_clk high and low phase is 3 cycles; latency 398; out_data=32'h5A5A_A5A5.
- Pulse start on every cycle during an operation: exactly one done, and out_data is unchanged by the extra pulses.
- Assert wb_rst_i mid-LOAD (cycle 20): outputs are 0 on the same cycle; a fresh start then completes with a correct result.
- Run a monitor for the whole bench: latch_enable&scan_clk is never 1, and scan_select only toggles while scan_clk=0.

Source files
------------

// File: rtl/scan_chain_driver.sv
// scan_chain_driver: sequences the clock, data, select and latch lines of a
// daisy-chained bank of scan-wrapped designs. It loads a parallel word into the
// chain, latches it into the designs, captures their outputs and shifts the
// captured bits back into a parallel result register.
module scan_chain_driver #(
  parameter int NUM_IOS     = 8,
  parameter int NUM_DESIGNS = 4,
  parameter int CLK_DIV     = 1,
  localparam int CHAIN_LEN  = NUM_IOS * NUM_DESIGNS
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] in_data,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] out_data,
  output logic                 scan_clk,
  output logic                 scan_data_out,
  output logic                 scan_select,
  output logic                 latch_enable,
  input  logic                 scan_data_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LATCH,
    S_CAPTURE,
    S_READ,
    S_FINISH
  } state_e;

  localparam int               BIT_W    = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);

  state_e               state_q, state_d;
  logic [7:0]           div_q, div_d;
  // Sub-phase: 0/1 = low/high half of a bit in LOAD/READ, 0..2 in CAPTURE.
  logic [1:0]           sub_q, sub_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [CHAIN_LEN-1:0] shift_q, shift_d;
  logic [CHAIN_LEN-1:0] rx_q, rx_d;
  logic [CHAIN_LEN-1:0] out_data_q, out_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 scan_clk_q, scan_clk_d;
  logic                 scan_data_out_q, scan_data_out_d;
  logic                 scan_select_q, scan_select_d;
  logic                 latch_enable_q, latch_enable_d;
  logic                 tick;

  // The sequencer only advances when the phase counter wraps.
  assign tick = (div_q == DIV_LAST);

  // Next-state sequencing, then chain-line values derived from the next state
  // so that every output flop reflects the state it is registered alongside.
  always_comb begin
    state_d    = state_q;
    div_d      = tick ? 8'd0 : div_q + 8'd1;
    sub_d      = sub_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    out_data_d = out_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        div_d = 8'd0;
        // A start coinciding with the done pulse is ignored.
        if (start && !done_q) begin
          shift_d = in_data;
          bit_d   = '0;
          sub_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (tick) begin
          if (sub_q == 2'd0) begin
            sub_d = 2'd1;
          end else begin
            sub_d   = 2'd0;
            shift_d = {shift_q[CHAIN_LEN-2:0], 1'b0};
            if (bit_q == LAST_BIT) begin
              bit_d   = '0;
              state_d = S_LATCH;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      S_LATCH: begin
        if (tick) begin
          sub_d   = 2'd0;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (tick) begin
          if (sub_q == 2'd2) begin
            sub_d   = 2'd0;
            state_d = S_READ;
          end else begin
            sub_d = sub_q + 2'd1;
          end
        end
      end
      S_READ: begin
        if (tick) begin
          if (sub_q == 2'd0) begin
            // Sample the chain output before the rising scan_clk shifts it.
            sub_d = 2'd1;
            rx_d  = {rx_q[CHAIN_LEN-2:0], scan_data_in};
          end else begin
            sub_d = 2'd0;
            if (bit_q == LAST_BIT) begin
              bit_d   = '0;
              state_d = S_FINISH;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      S_FINISH: begin
        out_data_d = rx_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      div_d = 8'd0;
    end

    scan_clk_d      = 1'b0;
    scan_data_out_d = 1'b0;
    scan_select_d   = 1'b0;
    latch_enable_d  = 1'b0;
    unique case (state_d)
      S_LOAD: begin
        scan_clk_d      = (sub_d == 2'd1);
        scan_data_out_d = shift_d[CHAIN_LEN-1];
      end
      S_LATCH: begin
        latch_enable_d = 1'b1;
      end
      S_CAPTURE: begin
        scan_select_d = (sub_d != 2'd2);
        scan_clk_d    = (sub_d == 2'd1);
      end
      S_READ: begin
        scan_clk_d = (sub_d == 2'd1);
      end
      default: begin
        scan_clk_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts straight back to idle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q         <= S_IDLE;
      div_q           <= 8'd0;
      sub_q           <= 2'd0;
      bit_q           <= '0;
      shift_q         <= '0;
      rx_q            <= '0;
      out_data_q      <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      scan_clk_q      <= 1'b0;
      scan_data_out_q <= 1'b0;
      scan_select_q   <= 1'b0;
      latch_enable_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      div_q           <= div_d;
      sub_q           <= sub_d;
      bit_q           <= bit_d;
      shift_q         <= shift_d;
      rx_q            <= rx_d;
      out_data_q      <= out_data_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      scan_clk_q      <= scan_clk_d;
      scan_data_out_q <= scan_data_out_d;
      scan_select_q   <= scan_select_d;
      latch_enable_q  <= latch_enable_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign out_data      = out_data_q;
  assign scan_clk      = scan_clk_q;
  assign scan_data_out = scan_data_out_q;
  assign scan_select   = scan_select_q;
  assign latch_enable  = latch_enable_q;

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver: two instances (CLK_DIV=1 and CLK_DIV=3), each
// driving a behavioural 4x8 scan chain whose designs output inputs ^ 8'hA5.
module tb_scan_chain_driver;

  localparam int N  = 2;
  localparam int CL = 32;

  logic clk = 1'b0;
  logic rst;

  logic          start_s    [N];
  logic [CL-1:0] in_data_s  [N];
  logic          busy_s     [N];
  logic          done_s     [N];
  logic [CL-1:0] out_data_s [N];
  logic          sclk_s     [N];
  logic          sdo_s      [N];
  logic          ssel_s     [N];
  logic          le_s       [N];
  logic          sdi_s      [N];

  typedef struct {
    int          inst;
    logic [31:0] din;
    logic [31:0] dout;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_inst
      localparam int DIV = (gi == 0) ? 1 : 3;
      logic [CL-1:0] flops;
      logic [CL-1:0] dsn_in;

      scan_chain_driver #(
        .NUM_IOS     (8),
        .NUM_DESIGNS (4),
        .CLK_DIV     (DIV)
      ) u_dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .start         (start_s[gi]),
        .in_data       (in_data_s[gi]),
        .busy          (busy_s[gi]),
        .done          (done_s[gi]),
        .out_data      (out_data_s[gi]),
        .scan_clk      (sclk_s[gi]),
        .scan_data_out (sdo_s[gi]),
        .scan_select   (ssel_s[gi]),
        .latch_enable  (le_s[gi]),
        .scan_data_in  (sdi_s[gi])
      );

      // Chain model: shift toward the far end, or capture design outputs.
      always @(posedge sclk_s[gi]) begin
        flops <= ssel_s[gi] ? (dsn_in ^ 32'hA5A5_A5A5) : {flops[CL-2:0], sdo_s[gi]};
      end
      // Designs latch the scan flops as their inputs.
      always @(posedge le_s[gi]) begin
        dsn_in <= flops;
      end
      assign sdi_s[gi] = flops[CL-1];
    end
  endgenerate

  function automatic void chk(input string name, input int inst,
                              input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s inst%0d: got 0x%08h (%0d) required 0x%08h (%0d)",
               name, inst, got, got, req, req);
    end
  endfunction

  // Monitor / scoreboard state, one slot per instance.
  int   lat_cnt [N];
  int   load_e  [N];
  int   cap_e   [N];
  int   read_e  [N];
  int   run_len [N];
  bit   active  [N];
  bit   latched [N];
  bit   seen_fall [N];
  logic prev_sclk [N];
  logic prev_ssel [N];

  initial begin : monitor
    exp_t e;
    int   dv;
    for (int i = 0; i < N; i++) begin
      active[i] = 1'b0;
      prev_sclk[i] = 1'b0;
      prev_ssel[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        dv = (i == 0) ? 1 : 3;
        if (rst) begin
          active[i]    = 1'b0;
          prev_sclk[i] = 1'b0;
          prev_ssel[i] = 1'b0;
        end else begin
          chk("le_and_sclk", i, 32'(le_s[i] & sclk_s[i]), 32'd0);
          if (ssel_s[i] !== prev_ssel[i]) begin
            chk("ssel_change_while_sclk", i, 32'(sclk_s[i]), 32'd0);
          end
          if (active[i]) begin
            lat_cnt[i]++;
            if (sclk_s[i] && !prev_sclk[i]) begin
              if (ssel_s[i]) cap_e[i]++;
              else if (latched[i]) read_e[i]++;
              else load_e[i]++;
              if (seen_fall[i]) begin
                n_cmp++;
                if (run_len[i] != dv && run_len[i] != 2 * dv) begin
                  n_fail++;
                  $display("FAIL low_phase inst%0d: got %0d cycles required %0d or %0d",
                           i, run_len[i], dv, 2 * dv);
                end
              end
              run_len[i] = 1;
            end else if (!sclk_s[i] && prev_sclk[i]) begin
              chk("high_phase", i, 32'(run_len[i]), 32'(dv));
              seen_fall[i] = 1'b1;
              run_len[i]   = 1;
            end else begin
              run_len[i]++;
            end
            if (le_s[i]) latched[i] = 1'b1;

            if (done_s[i]) begin
              active[i] = 1'b0;
              if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done inst%0d: got done with no pending request", i);
              end else begin
                e = exp_q.pop_front();
                chk("done_inst", i, 32'(i), 32'(e.inst));
                chk("out_data", i, out_data_s[i], e.dout);
                chk("latency", i, 32'(lat_cnt[i]), 32'(e.lat));
                chk("busy_at_done", i, 32'(busy_s[i]), 32'd0);
                chk("load_edges", i, 32'(load_e[i]), 32'd32);
                chk("capture_edges", i, 32'(cap_e[i]), 32'd1);
                chk("read_edges", i, 32'(read_e[i]), 32'd32);
                $display("op inst%0d in=%08h out=%08h lat=%0d", i, e.din, out_data_s[i], lat_cnt[i]);
              end
            end else begin
              chk("busy_high", i, 32'(busy_s[i]), 32'd1);
            end
          end else if (done_s[i]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL spurious_done inst%0d: got done while no operation accepted", i);
          end

          if (!active[i] && start_s[i] && !busy_s[i] && !done_s[i]) begin
            active[i]    = 1'b1;
            lat_cnt[i]   = 0;
            load_e[i]    = 0;
            cap_e[i]     = 0;
            read_e[i]    = 0;
            run_len[i]   = 0;
            latched[i]   = 1'b0;
            seen_fall[i] = 1'b0;
          end
          prev_sclk[i] = sclk_s[i];
          prev_ssel[i] = ssel_s[i];
        end
      end
    end
  end

  // Issue one request; caller is aligned just after a rising clock edge.
  task automatic run_op(input int inst, input logic [31:0] din,
                        input logic [31:0] dexp, input int lat);
    exp_t e;
    e.inst = inst;
    e.din  = din;
    e.dout = dexp;
    e.lat  = lat;
    exp_q.push_back(e);
    in_data_s[inst] = din;
    start_s[inst]   = 1'b1;
    @(posedge clk);
    #1;
    start_s[inst] = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending after %0d cycles required 0", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < N; i++) begin
      chk({name, "_ctrl"}, i,
          32'({busy_s[i], done_s[i], sclk_s[i], sdo_s[i], ssel_s[i], le_s[i]}), 32'd0);
      chk({name, "_out_data"}, i, out_data_s[i], 32'd0);
    end
  endtask

  initial begin : stimulus
    bit seen;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      start_s[i]   = 1'b0;
      in_data_s[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset: everything stays low.
    repeat (10) begin
      @(negedge clk);
      check_all_zero("idle");
    end
    @(posedge clk);
    #1;

    // Default divider, several patterns.
    run_op(0, 32'h0123_4567, 32'hA486_E0C2, 134);
    wait_drain(300);
    run_op(0, 32'h0000_0000, 32'hA5A5_A5A5, 134);
    wait_drain(300);
    run_op(0, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 134);
    wait_drain(300);

    // Divide-by-3 instance.
    run_op(1, 32'hFFFF_0000, 32'h5A5A_A5A5, 398);
    wait_drain(800);

    // Start pulsed every cycle of an operation, including the done cycle.
    exp_q.push_back('{0, 32'h89AB_CDEF, 32'h2C0E_684A, 134});
    in_data_s[0] = 32'h89AB_CDEF;
    start_s[0]   = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      #1;
      if (seen && !busy_s[0] && !done_s[0]) break;
      if (done_s[0]) seen = 1'b1;
      start_s[0] = busy_s[0] | done_s[0];
    end
    start_s[0] = 1'b0;
    wait_drain(300);
    repeat (150) @(posedge clk);
    #1;
    chk("out_data_hold", 0, out_data_s[0], 32'h2C0E_684A);

    // Reset in the middle of LOAD.
    run_op(0, 32'hDEAD_BEEF, 32'h7B08_1B4A, 134);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op(0, 32'h1357_9BDF, 32'hB6F2_3E7A, 134);
    wait_drain(300);

    repeat (200) @(posedge clk);
    #1;
    chk("final_pending", 0, 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish within time limit required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
